sw_handshake_sync: RTL and testbench
====================================

# sw_handshake_sync

Upstream input stage between the board switches and the picoMIPS core. It synchronises and debounces the asynchronous handshake switch (SW[8]) and the 8-bit data switches (SW[7:0]). On each debounced press it captures one data word and presents it to the core under a valid/ack handshake. It then waits for the switch to be released before arming for the next word.

## Interface
- DATA_W, 8, width of the switch data word
- DEBOUNCE_CYCLES, 500000, consecutive fastclk cycles a synchronised level must persist before it is accepted (10 ms at 50 MHz); must be ≥1, benches override to 4
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden)

Ports:
- fastclk  in  1  system clock, rising-edge
- n_reset  in  1  asynchronous, active-low reset (driven from SW[9])
- sw_data  in  DATA_W  raw data switches, asynchronous to fastclk
- sw_strobe  in  1  raw handshake switch, asynchronous to fastclk
- data_out  out  DATA_W  captured word; stable while data_valid=1
- data_valid  out  1  captured word available to core
- data_ack  in  1  core accepts word; ignored unless data_valid=1
- sw_level  out  1  debounced sw_strobe level (for program polling)
- overrun  out  1  sticky: a press occurred while a word was still unacknowledged

## Operation
- Synchroniser: sw_strobe and every sw_data bit each pass through two flops (s1, s2), all reset to 0.
- Debouncer on s2 of strobe:
  - counter cnt reset to 0; deb (= sw_level) reset to 0
  - s2 == deb → cnt <= 0
  - s2 != deb and cnt == DEBOUNCE_CYCLES-1 → deb <= s2, cnt <= 0
  - otherwise cnt <= cnt+1
  - any single-cycle agreement restarts the count; no saturation or wrap is possible
- deb_prev register holds last-cycle deb; rise = deb & ~deb_prev.
- FSM states IDLE, VALID, RELEASE; reset → IDLE:
  - IDLE: deb==1 → capture synchronised data into data_out, data_valid <= 1, → VALID
  - VALID: data_ack==1 → data_valid <= 0, → RELEASE; else hold. A rise in VALID (release then re-press before ack) sets overrun; data_out is not overwritten.
  - RELEASE: deb==0 → IDLE; else hold. A word is never captured twice from one press.
- overrun clears only on reset.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). A switch held high through reset release is seen as a fresh press.

## Timing
- Reset values: data_out=0, data_valid=0, sw_level=0, overrun=0, FSM=IDLE, cnt=0.
- Press latency, with N = DEBOUNCE_CYCLES:
  - sw_level rises on the (N+2)th rising edge after sw_strobe goes high, counting the first edge that samples it high as edge 1
  - data_valid rises on edge N+3
- data_out equals sw_data as synchronised two edges before the capture edge. sw_data must be stable from ≥2 cycles before the sw_strobe rise until capture.
- Ack latency: data_ack high at edge e with data_valid=1 → data_valid low after edge e. data_ack held high continuously while a new word becomes valid consumes that word on its first valid cycle (one-cycle pulse).
- Release: sw_level falls N+2 edges after sw_strobe goes low. If ack arrives after the release, RELEASE exits to IDLE one edge after entry.
- Minimum press-to-press period: 2(N+2)+3 cycles.

## Test plan
- Reset: hold n_reset=0 with switches toggling → all outputs 0. Release → still 0 while sw_strobe=0.
- Basic word (N=4): sw_data=8'hA5, then sw_strobe=1 → sw_level high at edge 6, data_valid high at edge 7 with data_out=8'hA5. Pulse data_ack → data_valid low next edge. Release strobe → sw_level low after 6 edges.
- Bounce rejection (N=4): sw_strobe high 3 cycles, low 1, high 3 → sw_level and data_valid stay 0. Then hold high → data_valid at N+3 from the final rise.
- Held switch: keep sw_strobe=1 after ack for 100 cycles with sw_data=8'h3C → no second data_valid. Release and re-press with 8'h3C → exactly one new word.
- Overrun: capture 8'h11, no ack, release and re-press with 8'h22 → overrun=1, data_out stays 8'h11. Ack → data_valid low; overrun stays 1 until n_reset.
- Reset mid-operation: drop n_reset while data_valid=1 → data_valid, data_out, sw_level=0 immediately. With strobe still held, after release data_valid returns at N+3 edges.

Source files
------------

// File: rtl/sw_handshake_sync.sv
// Switch input stage: synchronises and debounces the handshake switch, captures
// one data word per press and offers it to the core over a valid/ack handshake.
//
//   state   | meaning
//   IDLE    | armed, waiting for the debounced switch to be pressed
//   VALID   | word captured, waiting for the core to acknowledge it
//   RELEASE | word consumed, waiting for the switch to be released
module sw_handshake_sync #(
  parameter int DATA_W          = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              fastclk,
  input  logic              n_reset,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_strobe,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ack,
  output logic              sw_level,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, VALID, RELEASE} state_t;

  logic              strobe_s1, strobe_s2;
  logic [DATA_W-1:0] data_s1, data_s2;
  logic [CNT_W-1:0]  cnt;
  logic              deb, deb_prev, rise;
  state_t            state;

  always_ff @(posedge fastclk or negedge n_reset) begin
    if (!n_reset) begin
      strobe_s1 <= 1'b0;
      strobe_s2 <= 1'b0;
      data_s1   <= '0;
      data_s2   <= '0;
    end else begin
      strobe_s1 <= sw_strobe;
      strobe_s2 <= strobe_s1;
      data_s1   <= sw_data;
      data_s2   <= data_s1;
    end
  end

  // Any cycle where the synchronised level agrees with deb restarts the count.
  always_ff @(posedge fastclk or negedge n_reset) begin
    if (!n_reset) begin
      cnt      <= '0;
      deb      <= 1'b0;
      deb_prev <= 1'b0;
    end else begin
      deb_prev <= deb;
      if (strobe_s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= strobe_s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign rise     = deb & ~deb_prev;
  assign sw_level = deb;

  always_ff @(posedge fastclk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= IDLE;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (deb) begin
            data_out   <= data_s2;
            data_valid <= 1'b1;
            state      <= VALID;
          end
        end
        VALID: begin
          // A fresh press before the ack is flagged but never overwrites the word.
          if (rise) overrun <= 1'b1;
          if (data_ack) begin
            data_valid <= 1'b0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          if (!deb) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_handshake_sync.sv
// Bench for sw_handshake_sync: directed edge-count checks plus randomised switch
// activity compared every cycle against a window-based reference model.
module tb_sw_handshake_sync;

  localparam int N = 4;
  localparam int W = 8;

  logic         fastclk   = 1'b0;
  logic         n_reset   = 1'b0;
  logic         sw_strobe = 1'b0;
  logic         data_ack  = 1'b0;
  logic [W-1:0] sw_data   = '0;
  logic [W-1:0] data_out;
  logic         data_valid, sw_level, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  sw_handshake_sync #(.DATA_W(W), .DEBOUNCE_CYCLES(N)) dut (
    .fastclk    (fastclk),
    .n_reset    (n_reset),
    .sw_data    (sw_data),
    .sw_strobe  (sw_strobe),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ack   (data_ack),
    .sw_level   (sw_level),
    .overrun    (overrun)
  );

  always #5 fastclk = ~fastclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the level flips once the last N synchronised samples all
  // disagree with it; handshake tracked as pending / waiting-for-release flags.
  logic         m_sh [0:N];
  logic [W-1:0] m_dh [0:1];
  logic         m_level, m_prev, m_pending, m_wait, m_overrun, m_flip, m_rise;
  logic [W-1:0] m_word;

  always @(posedge fastclk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i <= N; i++) m_sh[i] = 1'b0;
      m_dh[0] = '0; m_dh[1] = '0;
      m_level = 1'b0; m_prev = 1'b0; m_pending = 1'b0; m_wait = 1'b0;
      m_overrun = 1'b0; m_word = '0;
    end else begin
      m_flip = 1'b1;
      for (int i = 1; i <= N; i++) if (m_sh[i] == m_level) m_flip = 1'b0;
      m_rise = m_level & ~m_prev;
      if (m_pending) begin
        if (m_rise) m_overrun = 1'b1;
        if (data_ack) begin m_pending = 1'b0; m_wait = 1'b1; end
      end else if (m_wait) begin
        if (!m_level) m_wait = 1'b0;
      end else if (m_level) begin
        m_word = m_dh[1];
        m_pending = 1'b1;
      end
      m_prev = m_level;
      if (m_flip) m_level = ~m_level;
      for (int i = N; i >= 1; i--) m_sh[i] = m_sh[i-1];
      m_sh[0] = sw_strobe;
      m_dh[1] = m_dh[0];
      m_dh[0] = sw_data;
    end
  end

  initial begin
    @(posedge fastclk);
    forever begin
      @(negedge fastclk);
      n_tests++;
      if (data_out !== m_word || data_valid !== m_pending ||
          sw_level !== m_level || overrun !== m_overrun) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t data_out %h/%h valid %b/%b level %b/%b overrun %b/%b (got/exp)",
                 $time, data_out, m_word, data_valid, m_pending, sw_level, m_level, overrun, m_overrun);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge fastclk);
  endtask

  // Call at a negedge: raises the strobe and checks the N+2 / N+3 edge latencies.
  task automatic press_measure(input string tag, input logic [W-1:0] exp_data);
    sw_strobe = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge fastclk); #1;
      check($sformatf("%s_level_e%0d", tag, e), 32'(sw_level), 32'(e >= 6));
      check($sformatf("%s_valid_e%0d", tag, e), 32'(data_valid), 32'(e >= 7));
    end
    check({tag, "_data"}, 32'(data_out), 32'(exp_data));
  endtask

  task automatic ack_pulse(input string tag);
    @(negedge fastclk);
    check({tag, "_valid_before_ack"}, 32'(data_valid), 32'd1);
    data_ack = 1'b1;
    @(posedge fastclk); #1;
    check({tag, "_valid_after_ack"}, 32'(data_valid), 32'd0);
    @(negedge fastclk);
    data_ack = 1'b0;
  endtask

  task automatic release_measure(input string tag);
    @(negedge fastclk);
    sw_strobe = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(posedge fastclk); #1;
      check($sformatf("%s_rel_level_e%0d", tag, e), 32'(sw_level), 32'(e < 6));
    end
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int k = 0;
    while (data_valid !== 1'b1 && k < budget) begin
      @(negedge fastclk);
      k++;
    end
    check({tag, "_wait_valid"}, 32'(data_valid), 32'd1);
  endtask

  int       rises, held_cnt;
  logic     pv;
  logic [W-1:0] got_word;

  initial begin
    // Reset held with switches toggling
    for (int i = 0; i < 8; i++) begin
      @(negedge fastclk);
      sw_strobe = 1'($urandom_range(0, 1));
      sw_data   = 8'($urandom);
    end
    @(negedge fastclk);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_level", 32'(sw_level), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    sw_strobe = 1'b0;
    sw_data   = '0;
    n_reset   = 1'b1;
    tick(8);
    check("post_rst_valid", 32'(data_valid), 32'd0);
    check("post_rst_level", 32'(sw_level), 32'd0);

    // Basic word
    sw_data = 8'hA5;
    tick(3);
    press_measure("basic", 8'hA5);
    check("model_level_basic", 32'(m_level), 32'd1);
    check("model_word_basic", 32'(m_word), 32'hA5);
    ack_pulse("basic");
    release_measure("basic");
    tick(3);

    // Bounce rejection: 3 high, 1 low, then held
    sw_data = 8'h5A;
    tick(3);
    sw_strobe = 1'b1;
    tick(3);
    sw_strobe = 1'b0;
    tick(1);
    check("bounce_level", 32'(sw_level), 32'd0);
    check("bounce_valid", 32'(data_valid), 32'd0);
    press_measure("bounce", 8'h5A);
    ack_pulse("bounce");
    release_measure("bounce");
    tick(3);

    // Held switch yields one word per press
    sw_data = 8'h3C;
    tick(3);
    press_measure("held1", 8'h3C);
    ack_pulse("held1");
    held_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge fastclk);
      if (data_valid) held_cnt++;
    end
    check("held_no_second", 32'(held_cnt), 32'd0);
    release_measure("held");
    tick(3);
    sw_strobe = 1'b1;
    rises = 0; pv = 1'b0; got_word = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge fastclk);
      if (data_valid && !pv) begin rises++; got_word = data_out; end
      pv = data_valid;
      data_ack = data_valid;
    end
    data_ack = 1'b0;
    check("held_one_word", 32'(rises), 32'd1);
    check("held_word_data", 32'(got_word), 32'h3C);
    sw_strobe = 1'b0;
    tick(10);

    // Overrun
    sw_data = 8'h11;
    tick(3);
    sw_strobe = 1'b1;
    wait_valid("ovr", 20);
    check("ovr_data1", 32'(data_out), 32'h11);
    @(negedge fastclk);
    sw_strobe = 1'b0;
    tick(10);
    check("ovr_not_yet", 32'(overrun), 32'd0);
    sw_data = 8'h22;
    tick(3);
    sw_strobe = 1'b1;
    tick(10);
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_data_kept", 32'(data_out), 32'h11);
    check("ovr_valid_held", 32'(data_valid), 32'd1);
    ack_pulse("ovr");
    sw_strobe = 1'b0;
    tick(12);
    check("ovr_sticky", 32'(overrun), 32'd1);
    check("ovr_valid_low", 32'(data_valid), 32'd0);
    @(negedge fastclk);
    n_reset = 1'b0;
    #1;
    check("ovr_cleared_by_rst", 32'(overrun), 32'd0);
    tick(2);
    n_reset = 1'b1;
    tick(3);

    // Reset mid-operation with strobe held
    sw_data = 8'h77;
    tick(3);
    press_measure("pre_rst", 8'h77);
    @(negedge fastclk);
    #2;
    n_reset = 1'b0;
    #1;
    check("midrst_valid", 32'(data_valid), 32'd0);
    check("midrst_data", 32'(data_out), 32'd0);
    check("midrst_level", 32'(sw_level), 32'd0);
    @(negedge fastclk);
    n_reset = 1'b1;
    press_measure("post_rst", 8'h77);
    ack_pulse("post_rst");
    release_measure("post_rst");
    tick(3);

    // Randomised switch activity
    for (int seg = 0; seg < 300; seg++) begin
      int len;
      len = $urandom_range(1, 14);
      sw_strobe = 1'($urandom_range(0, 1));
      for (int c = 0; c < len; c++) begin
        @(negedge fastclk);
        data_ack = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0) sw_data = 8'($urandom);
      end
      if ($urandom_range(0, 60) == 0) begin
        n_reset = 1'b0;
        @(negedge fastclk);
        n_reset = 1'b1;
      end
    end
    data_ack = 1'b0;
    tick(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
